// File: rtl/cipher_host.sv
// Host-side initiator for the XOR cipher UART box: sends key then plaintext as 8N1 frames and receives the reply byte.
// Optional comparator of the reply against plain^key is enabled by defining CIPHER_HOST_CHECK_EN.
module cipher_host #(
   parameter int CLK_FRE      = 50,
   parameter int BAUD_RATE    = 115200,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] plain,
   input  logic [7:0] key,
   output logic       tx_key,
   output logic       tx_data,
   input  logic       rx,
   output logic       busy,
   output logic [7:0] cipher,
   output logic       cipher_valid,
   output logic       frame_err,
   output logic       timeout,
   output logic       mismatch
);

   localparam int BIT_CYCLES = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int HALF       = BIT_CYCLES / 2;
   localparam int CW         = $clog2(BIT_CYCLES + 1);
   localparam int TW         = $clog2(TIMEOUT_BITS + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS - 1);

   typedef enum logic [2:0] {IDLE, SEND_KEY, SEND_DATA, WAIT_RX, RECV, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cyc;
   logic [3:0]    bit_idx;
   logic [CW-1:0] to_cyc;
   logic [TW-1:0] to_bits;
   logic [7:0]    plain_reg;
   logic [7:0]    key_reg;
   logic [7:0]    shreg;
   logic          rx_meta;
   logic          rx_s;
   logic          rx_prev;

   // Frame position 0 is the start bit, 1..8 are data LSB first, 9 is the stop bit.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      if (idx == 4'd0)
         return 1'b0;
      else if (idx >= 4'd9)
         return 1'b1;
      else
         return b[3'(idx - 4'd1)];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tx_key       <= 1'b1;
         tx_data      <= 1'b1;
         busy         <= 1'b0;
         cipher       <= 8'h00;
         cipher_valid <= 1'b0;
         frame_err    <= 1'b0;
         timeout      <= 1'b0;
         cyc          <= '0;
         bit_idx      <= 4'd0;
         to_cyc       <= '0;
         to_bits      <= '0;
         plain_reg    <= 8'h00;
         key_reg      <= 8'h00;
         shreg        <= 8'h00;
      end else begin
         cipher_valid <= 1'b0;
         frame_err    <= 1'b0;
         timeout      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  plain_reg <= plain;
                  key_reg   <= key;
                  tx_key    <= 1'b0;
                  busy      <= 1'b1;
                  cyc       <= '0;
                  bit_idx   <= 4'd0;
                  state     <= SEND_KEY;
               end
            end
            SEND_KEY: begin
               if (cyc == BIT_LAST) begin
                  cyc <= '0;
                  if (bit_idx == 4'd9) begin
                     bit_idx <= 4'd0;
                     tx_data <= 1'b0;
                     state   <= SEND_DATA;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     tx_key  <= frame_bit(key_reg, bit_idx + 4'd1);
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            SEND_DATA: begin
               if (cyc == BIT_LAST) begin
                  cyc <= '0;
                  if (bit_idx == 4'd9) begin
                     bit_idx <= 4'd0;
                     to_cyc  <= '0;
                     to_bits <= '0;
                     state   <= WAIT_RX;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     tx_data <= frame_bit(plain_reg, bit_idx + 4'd1);
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            WAIT_RX: begin
               // The timeout count is frozen while a candidate start bit is checked.
               if (rx_prev && !rx_s) begin
                  cyc     <= '0;
                  bit_idx <= 4'd0;
                  state   <= RECV;
               end else if (to_cyc == BIT_LAST) begin
                  to_cyc <= '0;
                  if (to_bits == TO_LAST) begin
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     to_bits <= to_bits + 1'b1;
                  end
               end else begin
                  to_cyc <= to_cyc + 1'b1;
               end
            end
            RECV: begin
               if (bit_idx == 4'd0) begin
                  if (cyc == HALF_LAST) begin
                     cyc <= '0;
                     if (rx_s)
                        state <= WAIT_RX;
                     else
                        bit_idx <= 4'd1;
                  end else begin
                     cyc <= cyc + 1'b1;
                  end
               end else if (cyc == BIT_LAST) begin
                  cyc <= '0;
                  if (bit_idx == 4'd9) begin
                     if (rx_s) begin
                        state <= DONE;
                     end else begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                     end
                  end else begin
                     shreg   <= {rx_s, shreg[7:1]};
                     bit_idx <= bit_idx + 4'd1;
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            DONE: begin
               cipher       <= shreg;
               cipher_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CIPHER_HOST_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mismatch <= 1'b0;
      else
         mismatch <= (state == DONE) && (shreg != (plain_reg ^ key_reg));
   end
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_host.sv
// Randomized scoreboard bench for cipher_host: serial frames decoded on both lines, reply pulses checked against queued expectations.
module tb_cipher_host;

   localparam int CLK_FRE      = 1;
   localparam int BAUD_RATE    = 80000;
   localparam int TIMEOUT_BITS = 20;
   localparam int BC           = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int HALF         = BC / 2;
`ifdef CIPHER_HOST_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef struct { logic [7:0] b; int t; } frame_t;
   typedef struct { int kind; logic [7:0] val; bit mm; int t; } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] plain = 8'h00;
   logic [7:0] key = 8'h00;
   logic       rx = 1'b1;
   logic       tx_key, tx_data, busy, cipher_valid, frame_err, timeout, mismatch;
   logic [7:0] cipher;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   frame_t key_q[$];
   frame_t data_q[$];
   exp_t   sb[$];
   logic [7:0] model_cipher = 8'h00;

   cipher_host #(
      .CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE), .TIMEOUT_BITS(TIMEOUT_BITS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .plain(plain), .key(key),
      .tx_key(tx_key), .tx_data(tx_data), .rx(rx), .busy(busy),
      .cipher(cipher), .cipher_valid(cipher_valid), .frame_err(frame_err),
      .timeout(timeout), .mismatch(mismatch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int got, input int want);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Serial line decoder: each frame is 10 bits of exactly BC cycles, start 0, data LSB first, stop 1.
   bit         act[2];
   int         fidx[2], fcnt[2], nbad[2];
   logic [7:0] want_b[2], acc[2];
   logic       ln, wb;
   frame_t     fr;
   initial begin
      for (int l = 0; l < 2; l++) act[l] = 1'b0;
      forever begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            ln = (l == 0) ? tx_key : tx_data;
            if (rst) begin
               act[l] = 1'b0;
               if (l == 0) key_q.delete(); else data_q.delete();
            end else if (!act[l]) begin
               if (!ln) begin
                  if ((l == 0 && key_q.size() == 0) || (l == 1 && data_q.size() == 0)) begin
                     total++; bad++;
                     $display("FAIL %s_start: got=unexpected frame want=idle line (cycle %0d)",
                              (l == 0) ? "key" : "data", cyc);
                     want_b[l] = 8'h00;
                  end else begin
                     if (l == 0) fr = key_q.pop_front(); else fr = data_q.pop_front();
                     chk(cyc == fr.t, (l == 0) ? "key_frame_time" : "data_frame_time", cyc, fr.t);
                     want_b[l] = fr.b;
                  end
                  act[l] = 1'b1; fidx[l] = 0; fcnt[l] = 1; nbad[l] = 0; acc[l] = 8'h00;
               end
            end else begin
               fcnt[l]++;
               if (fcnt[l] > BC) begin fidx[l]++; fcnt[l] = 1; end
               wb = (fidx[l] == 0) ? 1'b0 : (fidx[l] == 9) ? 1'b1 : want_b[l][fidx[l]-1];
               if (ln !== wb) nbad[l]++;
               if (fcnt[l] == HALF && fidx[l] >= 1 && fidx[l] <= 8) acc[l][fidx[l]-1] = ln;
               if (fidx[l] == 9 && fcnt[l] == BC) begin
                  act[l] = 1'b0;
                  chk(nbad[l] == 0 && acc[l] == want_b[l], (l == 0) ? "key_frame_bits" : "data_frame_bits",
                      {nbad[l][15:0], 8'h00, acc[l]}, {24'h0, want_b[l]});
               end
            end
         end
      end
   end

   // Reply monitor: pops one expectation per pulse.
   exp_t e;
   int   kind_got;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            model_cipher = 8'h00;
         end else begin
            if (mismatch && !cipher_valid) begin
               total++; bad++;
               $display("FAIL mismatch_alone: got=1 want=0 (cycle %0d)", cyc);
            end
            if (cipher_valid || frame_err || timeout) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL pulse_unexpected: got=%0b%0b%0b want=000 (cycle %0d)",
                           cipher_valid, frame_err, timeout, cyc);
               end else begin
                  e = sb.pop_front();
                  kind_got = cipher_valid ? 0 : frame_err ? 1 : 2;
                  chk(kind_got == e.kind && (int'(cipher_valid) + int'(frame_err) + int'(timeout)) == 1,
                      "pulse_kind", kind_got, e.kind);
                  if (e.kind == 0) begin
                     model_cipher = e.val;
                     chk(cipher == e.val, "cipher", cipher, e.val);
                     chk(mismatch == e.mm, "mismatch", mismatch, e.mm);
                  end else begin
                     chk(cipher == model_cipher, "cipher_hold", cipher, model_cipher);
                  end
                  if (e.kind == 2)
                     chk(cyc >= e.t - 1 && cyc <= e.t + 1, "timeout_time", cyc, e.t);
               end
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      logic [9:0] f;
      f = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (BC) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   // mode: 0 normal reply, 1 bad stop bit, 2 no reply, 3 glitch then reply, 4 normal with start pulsed while busy
   task automatic txn(input logic [7:0] p, input logic [7:0] k, input int mode, input logic [7:0] v);
      int n;
      bit gone;
      exp_t x;
      @(posedge clk); #1;
      plain = p; key = k; start = 1'b1;
      n = cyc + 1;
      key_q.push_back('{k, n});
      data_q.push_back('{p, n + 10 * BC});
      x.kind = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
      x.val  = v;
      x.mm   = CHECK_EN && (v != (p ^ k));
      x.t    = n + 20 * BC + TIMEOUT_BITS * BC;
      sb.push_back(x);
      @(posedge clk); #1;
      start = 1'b0; plain = 8'($urandom); key = 8'($urandom);
      for (int i = 1; i < 20 * BC; i++) begin
         @(posedge clk); #1;
         start = (mode == 4 && i == 15 * BC);
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (mode == 3) begin
         rx = 1'b0;
         repeat (3) @(posedge clk);
         #1; rx = 1'b1;
         repeat (BC) @(posedge clk);
         #1;
      end
      if (mode != 2) send_frame(v, mode != 1);
      gone = 1'b0;
      for (int i = 0; i < (TIMEOUT_BITS + 4) * BC; i++) begin
         @(posedge clk); #1;
         if (!busy) begin gone = 1'b1; break; end
      end
      chk(gone, "busy_drop", busy, 0);
      repeat (BC) @(posedge clk);
      #1;
      chk(!busy, "idle_after", busy, 0);
      $display("txn plain=%02h key=%02h mode=%0d reply=%02h cipher=%02h", p, k, mode, v, cipher);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got=no finish want=finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] p, k, v;
      int md;
      repeat (3) @(posedge clk);
      #1;
      chk(tx_key == 1'b1, "reset_tx_key", tx_key, 1);
      chk(tx_data == 1'b1, "reset_tx_data", tx_data, 1);
      chk(busy == 1'b0, "reset_busy", busy, 0);
      chk(cipher == 8'h00, "reset_cipher", cipher, 0);
      chk({cipher_valid, frame_err, timeout, mismatch} == 4'b0, "reset_pulses",
          {cipher_valid, frame_err, timeout, mismatch}, 0);
      rst = 1'b0;

      txn(8'h5A, 8'h3C, 0, 8'h66);
      txn(8'h5A, 8'h3C, 2, 8'h00);
      txn(8'h5A, 8'h3C, 0, 8'h00);
      txn(8'h11, 8'h22, 1, 8'h33);
      txn(8'hF0, 8'h55, 3, 8'hA5);
      txn(8'h12, 8'h34, 4, 8'h26);

      // Abort a transaction partway through the key frame.
      @(posedge clk); #1;
      plain = 8'h77; key = 8'h96; start = 1'b1;
      key_q.push_back('{8'h96, cyc + 1});
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3 * BC + 5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk(tx_key == 1'b1, "rst_mid_tx_key", tx_key, 1);
      chk(busy == 1'b0, "rst_mid_busy", busy, 0);
      chk(cipher == 8'h00, "rst_mid_cipher", cipher, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      txn(8'h96, 8'h69, 0, 8'hFF);

      for (int i = 0; i < 12; i++) begin
         p  = 8'($urandom);
         k  = 8'($urandom);
         md = $urandom_range(0, 4);
         v  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (p ^ k);
         txn(p, k, md, v);
      end

      repeat (4) @(posedge clk);
      #1;
      chk(sb.size() == 0 && key_q.size() == 0 && data_q.size() == 0, "queues_drained",
          sb.size() + key_q.size() + data_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
